// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: opcodes, FSM states and the
// request record held in the pending slot.
package mem_pkg;

    localparam logic MEM_OP_RD = 1'b0;
    localparam logic MEM_OP_WR = 1'b1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Widest len/idx a responder instance may use; instances zero-extend into these.
    localparam int REQ_LEN_MAX = 16;
    localparam int REQ_IDX_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        READ  = ST_READ,
        WRITE = ST_WRITE
    } state_t;

    typedef struct packed {
        logic                   opcode;
        logic [REQ_LEN_MAX-1:0] len;
        logic [REQ_IDX_MAX-1:0] idx;
    } mem_req_t;

endpackage

// File: rtl/mem_resp_store.sv
// Word store for the responder: two write ports (burst wins over init on the
// same word) and one asynchronous read port.
module mem_resp_store #(
    parameter int DATA_BITS  = 64,
    parameter int DEPTH_BITS = 10
) (
    input  logic                  i_clock,
    input  logic                  i_burstWe,
    input  logic [DEPTH_BITS-1:0] i_burstAddr,
    input  logic [DATA_BITS-1:0]  i_burstData,
    input  logic                  i_initWe,
    input  logic [DEPTH_BITS-1:0] i_initAddr,
    input  logic [DATA_BITS-1:0]  i_initData,
    input  logic [DEPTH_BITS-1:0] i_rdAddr,
    output logic [DATA_BITS-1:0]  o_rdData
);

    logic [DATA_BITS-1:0] r_mem [2**DEPTH_BITS];

    // The burst write is issued last so it overrides a same-word init write.
    always_ff @(posedge i_clock) begin
        if (i_initWe) begin
            r_mem[i_initAddr] <= i_initData;
        end
        if (i_burstWe) begin
            r_mem[i_burstAddr] <= i_burstData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves read/write bursts from an on-chip word store,
// with a one-entry pending request slot and a preload port.
module mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_LEN_BITS   = 8,
    parameter int MEM_ADDR_BITS  = 32,
    parameter int MEM_DATA_BITS  = 64,
    parameter int MEM_DEPTH_BITS = 10
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      mem_req_valid,
    input  logic                      mem_req_opcode,
    input  logic [MEM_LEN_BITS-1:0]   mem_req_len,
    input  logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
    input  logic                      mem_wr_valid,
    input  logic [MEM_DATA_BITS-1:0]  mem_wr_bits,
    output logic                      mem_rd_valid,
    output logic [MEM_DATA_BITS-1:0]  mem_rd_bits,
    input  logic                      mem_rd_ready,
    input  logic                      init_valid,
    input  logic [MEM_DEPTH_BITS-1:0] init_addr,
    input  logic [MEM_DATA_BITS-1:0]  init_data,
    output logic                      busy,
    output logic                      overflow
);

    localparam int OFF_BITS = $clog2(MEM_DATA_BITS / 8);

    state_t                    r_state;
    logic [MEM_DEPTH_BITS-1:0] r_idx;
    logic [MEM_LEN_BITS-1:0]   r_cnt;
    mem_req_t                  r_pend;
    logic                      r_pendValid;
    logic                      r_overflow;
    logic                      r_rdValid;
    logic [MEM_DATA_BITS-1:0]  r_rdBits;

    logic [MEM_DEPTH_BITS-1:0] w_reqIdx;
    mem_req_t                  w_reqPkt;
    logic                      w_pop;
    logic                      w_direct;
    logic                      w_launch;
    logic                      w_launchOp;
    logic [MEM_LEN_BITS-1:0]   w_launchLen;
    logic [MEM_DEPTH_BITS-1:0] w_launchIdx;
    logic                      w_rdBeat;
    logic                      w_wrBeat;
    logic                      w_last;
    logic [MEM_DEPTH_BITS-1:0] w_nextIdx;
    logic [MEM_DEPTH_BITS-1:0] w_storeRdIdx;
    logic [MEM_DATA_BITS-1:0]  w_storeRdData;
    logic                      w_unusedPendBits;

    // A pending request is launched from IDLE, so a burst finishing with a
    // full slot spends exactly one IDLE cycle before the next burst runs.
    always_comb begin
        w_reqIdx                              = MEM_DEPTH_BITS'(mem_req_addr >> OFF_BITS);
        w_reqPkt                              = '0;
        w_reqPkt.opcode                       = mem_req_opcode;
        w_reqPkt.len[MEM_LEN_BITS-1:0]        = mem_req_len;
        w_reqPkt.idx[MEM_DEPTH_BITS-1:0]      = w_reqIdx;

        w_pop    = (r_state == IDLE) && r_pendValid;
        w_direct = (r_state == IDLE) && !r_pendValid && mem_req_valid;
        w_launch = w_pop || w_direct;

        if (w_pop) begin
            w_launchOp  = r_pend.opcode;
            w_launchLen = r_pend.len[MEM_LEN_BITS-1:0];
            w_launchIdx = r_pend.idx[MEM_DEPTH_BITS-1:0];
        end else begin
            w_launchOp  = mem_req_opcode;
            w_launchLen = mem_req_len;
            w_launchIdx = w_reqIdx;
        end

        w_rdBeat     = (r_state == READ) && r_rdValid && mem_rd_ready;
        w_wrBeat     = (r_state == WRITE) && mem_wr_valid;
        w_last       = (r_cnt == '0);
        w_nextIdx    = r_idx + MEM_DEPTH_BITS'(1);
        w_storeRdIdx = w_launch ? w_launchIdx : w_nextIdx;
    end

    assign w_unusedPendBits = &{1'b0, r_pend.len, r_pend.idx};

    mem_resp_store #(
        .DATA_BITS  (MEM_DATA_BITS),
        .DEPTH_BITS (MEM_DEPTH_BITS)
    ) u_store (
        .i_clock     (clock),
        .i_burstWe   (w_wrBeat),
        .i_burstAddr (r_idx),
        .i_burstData (mem_wr_bits),
        .i_initWe    (init_valid),
        .i_initAddr  (init_addr),
        .i_initData  (init_data),
        .i_rdAddr    (w_storeRdIdx),
        .o_rdData    (w_storeRdData)
    );

    // Read data is only reloaded on launch or a taken beat, so it stays stable
    // across stalls even if the word underneath is rewritten by a preload.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_rdValid <= 1'b0;
            r_rdBits  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_launch) begin
                        r_idx <= w_launchIdx;
                        r_cnt <= w_launchLen;
                        if (w_launchOp == MEM_OP_RD) begin
                            r_state   <= READ;
                            r_rdValid <= 1'b1;
                            r_rdBits  <= w_storeRdData;
                        end else begin
                            r_state <= WRITE;
                        end
                    end
                end
                READ: begin
                    if (w_rdBeat) begin
                        if (w_last) begin
                            r_state   <= IDLE;
                            r_rdValid <= 1'b0;
                        end else begin
                            r_idx    <= w_nextIdx;
                            r_cnt    <= r_cnt - MEM_LEN_BITS'(1);
                            r_rdBits <= w_storeRdData;
                        end
                    end
                end
                WRITE: begin
                    if (w_wrBeat) begin
                        r_idx <= w_nextIdx;
                        if (w_last) begin
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt - MEM_LEN_BITS'(1);
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rdValid <= 1'b0;
                end
            endcase
        end
    end

    // The slot frees in the same cycle it is popped, so a request arriving
    // then refills it instead of being dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pend      <= '0;
            r_pendValid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (mem_req_valid && !w_direct) begin
                if (!r_pendValid || w_pop) begin
                    r_pend      <= w_reqPkt;
                    r_pendValid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (w_pop) begin
                r_pendValid <= 1'b0;
            end
        end
    end

    assign mem_rd_valid = r_rdValid;
    assign mem_rd_bits  = r_rdBits;
    assign busy         = (r_state != IDLE) || r_pendValid;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// bursts checked against a word-array model of the store.
module tb_mem_responder;

    localparam int LEN_BITS   = 8;
    localparam int ADDR_BITS  = 32;
    localparam int DATA_BITS  = 64;
    localparam int DEPTH_BITS = 4;
    localparam int DEPTH      = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  mem_req_valid;
    logic                  mem_req_opcode;
    logic [LEN_BITS-1:0]   mem_req_len;
    logic [ADDR_BITS-1:0]  mem_req_addr;
    logic                  mem_wr_valid;
    logic [DATA_BITS-1:0]  mem_wr_bits;
    logic                  mem_rd_valid;
    logic [DATA_BITS-1:0]  mem_rd_bits;
    logic                  mem_rd_ready;
    logic                  init_valid;
    logic [DEPTH_BITS-1:0] init_addr;
    logic [DATA_BITS-1:0]  init_data;
    logic                  busy;
    logic                  overflow;

    logic [DATA_BITS-1:0] model [DEPTH];
    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clock = ~clock;

    mem_responder #(
        .MEM_LEN_BITS   (LEN_BITS),
        .MEM_ADDR_BITS  (ADDR_BITS),
        .MEM_DATA_BITS  (DATA_BITS),
        .MEM_DEPTH_BITS (DEPTH_BITS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req_valid  (mem_req_valid),
        .mem_req_opcode (mem_req_opcode),
        .mem_req_len    (mem_req_len),
        .mem_req_addr   (mem_req_addr),
        .mem_wr_valid   (mem_wr_valid),
        .mem_wr_bits    (mem_wr_bits),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_bits    (mem_rd_bits),
        .mem_rd_ready   (mem_rd_ready),
        .init_valid     (init_valid),
        .init_addr      (init_addr),
        .init_data      (init_data),
        .busy           (busy),
        .overflow       (overflow)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Byte address for a word index, with random offset and out-of-range high bits.
    function automatic logic [31:0] makeAddr(input int idx);
        logic [31:0] a;
        a = ($urandom() << 7) | (32'(idx) << 3) | 32'($urandom_range(0, 7));
        return a;
    endfunction

    task automatic applyStimulus(input logic op, input int idx, input int len);
        mem_req_valid  = 1'b1;
        mem_req_opcode = op;
        mem_req_len    = LEN_BITS'(len);
        mem_req_addr   = makeAddr(idx);
    endtask

    task automatic preload(input int idx, input logic [63:0] data);
        init_valid = 1'b1;
        init_addr  = DEPTH_BITS'(idx);
        init_data  = data;
        @(negedge clock);
        init_valid = 1'b0;
        model[idx] = data;
    endtask

    // readyMode: 0 = always ready, 1 = pattern 1,0,0,1,1, otherwise random.
    task automatic readBurst(input int idx, input int len, input int readyMode);
        int got;
        int cyc;
        logic [4:0] pat;
        pat = 5'b11001;
        applyStimulus(1'b0, idx, len);
        @(negedge clock);
        mem_req_valid = 1'b0;
        checkOutput("rdFirstValid", 64'(mem_rd_valid), 64'd1);
        got = 0;
        cyc = 0;
        while (got <= len && cyc < 400) begin
            if (readyMode == 0)      mem_rd_ready = 1'b1;
            else if (readyMode == 1) mem_rd_ready = pat[cyc % 5];
            else                     mem_rd_ready = 1'($urandom_range(0, 1));
            checkOutput("rdValid", 64'(mem_rd_valid), 64'd1);
            if (!mem_rd_valid) break;
            checkOutput("rdData", mem_rd_bits, model[(idx + got) % DEPTH]);
            if (mem_rd_ready) got++;
            cyc++;
            @(negedge clock);
        end
        mem_rd_ready = 1'b0;
        checkOutput("rdBeats", 64'(got), 64'(len + 1));
        checkOutput("rdDone", 64'(mem_rd_valid), 64'd0);
        checkOutput("rdBusyEnd", 64'(busy), 64'd0);
    endtask

    // gapMode: 0 = directed valid pattern 1,0,1,1,0,1 with fixed data,
    // otherwise random gaps, random data and colliding preloads.
    task automatic writeBurst(input int idx, input int len, input int gapMode);
        int sent;
        int cyc;
        logic v;
        logic [63:0] data;
        logic [5:0] pat;
        pat = 6'b101101;
        applyStimulus(1'b1, idx, len);
        mem_wr_valid = 1'b1;
        mem_wr_bits  = ~model[idx];
        @(negedge clock);
        mem_req_valid = 1'b0;
        checkOutput("wrBusy", 64'(busy), 64'd1);
        sent = 0;
        cyc  = 0;
        while (sent <= len && cyc < 400) begin
            v = (gapMode == 0) ? pat[cyc % 6] : ($urandom_range(0, 3) != 0);
            mem_wr_valid = v;
            init_valid   = 1'b0;
            if (v) begin
                data = (gapMode == 0) ? (64'hDA7A_0000_0000_000A + 64'(sent))
                                      : {$urandom(), $urandom()};
                mem_wr_bits = data;
                model[(idx + sent) % DEPTH] = data;
                if (gapMode != 0 && $urandom_range(0, 1) == 1) begin
                    init_valid = 1'b1;
                    init_addr  = DEPTH_BITS'((idx + sent) % DEPTH);
                    init_data  = ~data;
                end
                sent++;
            end
            cyc++;
            @(negedge clock);
        end
        mem_wr_valid = 1'b0;
        init_valid   = 1'b0;
        checkOutput("wrBusyEnd", 64'(busy), 64'd0);
    endtask

    initial begin
        mem_req_valid  = 1'b0;
        mem_req_opcode = 1'b0;
        mem_req_len    = '0;
        mem_req_addr   = '0;
        mem_wr_valid   = 1'b0;
        mem_wr_bits    = '0;
        mem_rd_ready   = 1'b0;
        init_valid     = 1'b0;
        init_addr      = '0;
        init_data      = '0;
        reset          = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("rstRdValid", 64'(mem_rd_valid), 64'd0);
        checkOutput("rstRdBits", mem_rd_bits, 64'd0);
        checkOutput("rstBusy", 64'(busy), 64'd0);
        checkOutput("rstOverflow", 64'(overflow), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < DEPTH; i++) preload(i, {$urandom(), $urandom()});
        preload(0, 64'h11);
        preload(1, 64'h22);
        preload(2, 64'h33);
        preload(3, 64'h44);

        readBurst(1, 2, 0);
        readBurst(1, 2, 1);
        writeBurst(0, 3, 0);
        readBurst(0, 3, 0);
        readBurst(15, 1, 0);
        writeBurst(5, 0, 1);
        readBurst(5, 0, 0);

        // Two writes during a 4-beat read: first queues, second is dropped.
        applyStimulus(1'b0, 0, 3);
        mem_rd_ready = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 4; k++) begin
            checkOutput("qRdValid", 64'(mem_rd_valid), 64'd1);
            checkOutput("qRdData", mem_rd_bits, model[k]);
            mem_req_valid = 1'b0;
            if (k == 0) applyStimulus(1'b1, 8, 1);
            if (k == 1) applyStimulus(1'b1, 12, 0);
            @(negedge clock);
        end
        mem_req_valid = 1'b0;
        mem_rd_ready  = 1'b0;
        checkOutput("qRdDone", 64'(mem_rd_valid), 64'd0);
        checkOutput("qBusyPending", 64'(busy), 64'd1);
        checkOutput("qOverflow", 64'(overflow), 64'd1);
        repeat (3) @(negedge clock);
        checkOutput("qBusyWait", 64'(busy), 64'd1);
        for (int k = 0; k < 2; k++) begin
            mem_wr_valid = 1'b1;
            mem_wr_bits  = {$urandom(), $urandom()};
            model[8 + k] = mem_wr_bits;
            @(negedge clock);
        end
        mem_wr_valid = 1'b0;
        checkOutput("qBusyEnd", 64'(busy), 64'd0);
        checkOutput("qOverflowSticky", 64'(overflow), 64'd1);
        readBurst(8, 1, 0);
        readBurst(12, 0, 0);

        // Reset during the second beat of a 4-beat read.
        applyStimulus(1'b0, 0, 3);
        mem_rd_ready = 1'b1;
        @(negedge clock);
        mem_req_valid = 1'b0;
        checkOutput("arRdData0", mem_rd_bits, model[0]);
        @(negedge clock);
        checkOutput("arRdValid1", 64'(mem_rd_valid), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("arRdValid", 64'(mem_rd_valid), 64'd0);
        checkOutput("arRdBits", mem_rd_bits, 64'd0);
        checkOutput("arBusy", 64'(busy), 64'd0);
        checkOutput("arOverflow", 64'(overflow), 64'd0);
        @(negedge clock);
        reset        = 1'b0;
        mem_rd_ready = 1'b0;
        @(negedge clock);
        readBurst(0, 3, 0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 2))
                0:       preload($urandom_range(0, DEPTH - 1), {$urandom(), $urandom()});
                1:       readBurst($urandom_range(0, DEPTH - 1), $urandom_range(0, 20), 2);
                default: writeBurst($urandom_range(0, DEPTH - 1), $urandom_range(0, 20), 1);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
